player_move_sched: RTL
======================

Name: player_move_sched

Overview:
Per-frame movement scheduler for the two Bomberman players. It decodes the PS/2 scancode byte stream (data_out/data_valide) into held-key vectors for both players. On each qualifying end-of-frame it sequences position updates: player 1 first, then player 2, with screen-edge clamping and a no-overlap rule. Its position outputs feed the sprite/display path.

Parameters:
HACTIVE, 800, horizontal active pixels; X legal range 0..HACTIVE-1
VACTIVE, 600, vertical active pixels; Y legal range 0..VACTIVE-1
STEP, 2, pixels moved per axis per update (1..15)
FRAME_DIV, 1, update on every FRAME_DIV-th EOF (1..255)
P1_X0 / P1_Y0, 200 / 300, player 1 reset position
P2_X0 / P2_Y0, 600 / 300, player 2 reset position

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
eof  in  1  end-of-frame level from the VGA timing block
data_out  in  8  PS/2 scancode byte (set 2)
data_valide  in  1  one-cycle strobe; data_out valid
p1_x, p1_y  out  11 signed  player 1 center
p2_x, p2_y  out  11 signed  player 2 center
keys_p1  out  4  held keys {up,down,left,right}, player 1
keys_p2  out  4  held keys {up,down,left,right}, player 2
upd_done  out  1  one-cycle pulse after player 2 commit

Behaviour:
- Reset: positions at P*_X0/P*_Y0; keys_p1 = keys_p2 = 0; upd_done = 0; frame counter = 0; both FSMs in their idle states. Reset asserted mid-update aborts the update with no partial commit.
- Decoder FSM (acts only on data_valide cycles):
  - States: WAIT, BRK, EXT, EXT_BRK.
  - WAIT: 0xF0 -> BRK; 0xE0 -> EXT; any other code = make.
  - EXT: 0xF0 -> EXT_BRK; other = extended make, then -> WAIT.
  - BRK and EXT_BRK: byte = break code, then -> WAIT.
  - Player 1 (plain codes): 0x1D up, 0x1B down, 0x1C left, 0x23 right.
  - Player 2 (extended codes): 0x75 up, 0x72 down, 0x6B left, 0x74 right.
  - Make sets the matching bit; break clears it. Unmapped codes change no bit but still complete the FSM transition.
  - Key bits update the cycle after data_valide.
- Frame qualifier:
  - eof_rise = eof & ~eof_q.
  - Each eof_rise increments a modulo-FRAME_DIV counter; the wrap cycle is a "tick".
  - A tick arriving while the scheduler is not in IDLE is dropped.
- Scheduler FSM: IDLE -> SNAP -> MOVE_P1 -> MOVE_P2 -> DONE -> IDLE.
  - SNAP: latch keys_p1/keys_p2. Key events after this cycle wait for the next tick.
  - MOVE_P1: commit candidate p1.
  - MOVE_P2: commit candidate p2.
  - DONE: upd_done = 1 for exactly one cycle.
  - Latency: tick edge to p1 update = 2 cycles; to p2 update = 3 cycles; to upd_done = 4 cycles.
- Candidate arithmetic:
  - Computed in 12-bit signed: dx = (right - left) * STEP, dy = (down - up) * STEP.
  - Opposite keys held together cancel to 0 on that axis.
  - Clamp each axis independently to [0, HACTIVE-1] / [0, VACTIVE-1] before committing.
- Overlap rule:
  - A player's candidate (x, y) exactly equal to the other player's current position is rejected; that player keeps both coordinates.
  - P2 compares against p1's already-committed value from this tick.

Optional Feature:
MOVE_DIAG_EN
- Defined: X and Y update in the same tick (diagonal motion).
- Undefined: only one axis moves per tick. Horizontal has priority when dx != 0; otherwise vertical.

Decomposition:
- Package bomber_pkg holds: HACTIVE/VACTIVE defaults, the eight scancode constants, PS2_BRK = 0xF0, PS2_EXT = 0xE0, a typedef for the decoder state enum, a typedef for the scheduler state enum, and a typedef for the 11-bit signed coordinate.
- One sub-module, ps2_key_decoder: decoder FSM plus both key vectors.

Test Plan:
- Reset: assert reset mid-MOVE_P1 -> p1 = (200,300), p2 = (600,300), keys = 0, upd_done low.
- P1 right: bytes 0x23, one tick, FRAME_DIV=1, STEP=2 -> p1_x = 202 at tick+2, upd_done at tick+4. Then bytes F0,23 -> keys_p1 = 0; next tick leaves p1 unchanged.
- P2 up: bytes E0,75 -> keys_p2 = 4'b1000; tick -> p2_y = 298. Then E0,F0,75 -> bit cleared.
- Clamp: p1 at x=1, left held, STEP=2 -> p1_x = 0; hold further -> stays 0. P2 at y=598, down held -> 599.
- Overlap: p1 at (402,300), p2 at (404,300), p1 idle, p2 left held -> p2 stays at (404,300).
- Diagonal: up+right held on p1. MOVE_DIAG_EN defined -> (202,298). Undefined -> (202,300).

Source files
------------

// File: rtl/bomber_pkg.sv
// -----------------------------------------------------------------------------
// bomber_pkg
// Shared definitions for the Bomberman player movement path: default screen
// size, PS/2 set-2 scancodes for both players, decoder and scheduler state
// types, the on-screen coordinate type, and a scancode-to-key-bit mapper.
// Key vectors are ordered {up, down, left, right} (bit 3 .. bit 0).
// -----------------------------------------------------------------------------
package bomber_pkg;

    localparam int HACTIVE_DEF = 800;
    localparam int VACTIVE_DEF = 600;

    // PS/2 prefix bytes
    localparam logic [7:0] PS2_BRK = 8'hF0;
    localparam logic [7:0] PS2_EXT = 8'hE0;

    // Player 1: plain codes
    localparam logic [7:0] KEY_P1_UP    = 8'h1D;
    localparam logic [7:0] KEY_P1_DOWN  = 8'h1B;
    localparam logic [7:0] KEY_P1_LEFT  = 8'h1C;
    localparam logic [7:0] KEY_P1_RIGHT = 8'h23;

    // Player 2: extended (E0-prefixed) codes
    localparam logic [7:0] KEY_P2_UP    = 8'h75;
    localparam logic [7:0] KEY_P2_DOWN  = 8'h72;
    localparam logic [7:0] KEY_P2_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_P2_RIGHT = 8'h74;

    typedef enum logic [1:0] {
        DEC_WAIT,
        DEC_BRK,
        DEC_EXT,
        DEC_EXT_BRK
    } dec_state_t;

    typedef enum logic [2:0] {
        SCH_IDLE,
        SCH_SNAP,
        SCH_MOVE_P1,
        SCH_MOVE_P2,
        SCH_DONE
    } sch_state_t;

    typedef logic signed [10:0] coord_t;

    // One-hot key bit for a scancode; plain codes belong to player 1,
    // extended codes to player 2. Unmapped codes give an empty mask.
    function automatic logic [3:0] key_mask(input logic [7:0] code, input logic ext);
        logic [3:0] m;
        m = 4'b0000;
        if (!ext) begin
            case (code)
                KEY_P1_UP:    m = 4'b1000;
                KEY_P1_DOWN:  m = 4'b0100;
                KEY_P1_LEFT:  m = 4'b0010;
                KEY_P1_RIGHT: m = 4'b0001;
                default:      m = 4'b0000;
            endcase
        end else begin
            case (code)
                KEY_P2_UP:    m = 4'b1000;
                KEY_P2_DOWN:  m = 4'b0100;
                KEY_P2_LEFT:  m = 4'b0010;
                KEY_P2_RIGHT: m = 4'b0001;
                default:      m = 4'b0000;
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/ps2_key_decoder.sv
// -----------------------------------------------------------------------------
// ps2_key_decoder
// Turns the PS/2 set-2 byte stream into held-key vectors for both players.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   data_out     scancode byte, valid when data_valide is high
//   data_valide  one-cycle byte strobe
//   keys_p1/p2   held keys {up,down,left,right}; update the cycle after the strobe
// -----------------------------------------------------------------------------
module ps2_key_decoder
    import bomber_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_out,
    input  logic       data_valide,
    output logic [3:0] keys_p1,
    output logic [3:0] keys_p2
);

    dec_state_t state;
    logic [3:0] mask;

    // The byte after an E0 prefix (with or without F0) is a player-2 code.
    assign mask = key_mask(data_out, (state == DEC_EXT) || (state == DEC_EXT_BRK));

    // NOTE: state and key registers use non-blocking assignments so every
    // update in this block sees the pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= DEC_WAIT;
            keys_p1 <= 4'b0000;
            keys_p2 <= 4'b0000;
        end else if (data_valide) begin
            case (state)
                DEC_WAIT: begin
                    if (data_out == PS2_BRK)      state <= DEC_BRK;
                    else if (data_out == PS2_EXT) state <= DEC_EXT;
                    else                          keys_p1 <= keys_p1 | mask;
                end
                DEC_EXT: begin
                    if (data_out == PS2_BRK) begin
                        state <= DEC_EXT_BRK;
                    end else begin
                        keys_p2 <= keys_p2 | mask;
                        state   <= DEC_WAIT;
                    end
                end
                DEC_BRK: begin
                    keys_p1 <= keys_p1 & ~mask;
                    state   <= DEC_WAIT;
                end
                DEC_EXT_BRK: begin
                    keys_p2 <= keys_p2 & ~mask;
                    state   <= DEC_WAIT;
                end
                default: state <= DEC_WAIT;
            endcase
        end
    end

endmodule

// File: rtl/player_move_sched.sv
// -----------------------------------------------------------------------------
// player_move_sched
// Per-frame movement scheduler for the two players. On each qualifying
// end-of-frame it snapshots the held keys, then moves player 1, then player 2,
// clamping to the screen and refusing any move onto the other player.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   eof               end-of-frame level; its rising edge feeds the frame divider
//   data_out          PS/2 scancode byte
//   data_valide       one-cycle byte strobe
//   p1_x/p1_y         player 1 center (signed 11 bit)
//   p2_x/p2_y         player 2 center (signed 11 bit)
//   keys_p1/keys_p2   held keys {up,down,left,right}
//   upd_done          one-cycle pulse after the player 2 commit
// Build option: define MOVE_DIAG_EN to let both axes move in one update;
// otherwise a horizontal move takes priority and suppresses the vertical one.
// -----------------------------------------------------------------------------
module player_move_sched
    import bomber_pkg::*;
#(
    parameter int HACTIVE   = HACTIVE_DEF,
    parameter int VACTIVE   = VACTIVE_DEF,
    parameter int STEP      = 2,
    parameter int FRAME_DIV = 1,
    parameter int P1_X0     = 200,
    parameter int P1_Y0     = 300,
    parameter int P2_X0     = 600,
    parameter int P2_Y0     = 300
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               eof,
    input  logic [7:0]         data_out,
    input  logic               data_valide,
    output logic signed [10:0] p1_x,
    output logic signed [10:0] p1_y,
    output logic signed [10:0] p2_x,
    output logic signed [10:0] p2_y,
    output logic [3:0]         keys_p1,
    output logic [3:0]         keys_p2,
    output logic               upd_done
);

    localparam logic signed [11:0] X_MAX   = 12'(HACTIVE - 1);
    localparam logic signed [11:0] Y_MAX   = 12'(VACTIVE - 1);
    localparam logic signed [11:0] STEP_S  = 12'(STEP);
    localparam logic [7:0]         DIV_TOP = 8'(FRAME_DIV - 1);

    ps2_key_decoder u_decoder (
        .clk         (clk),
        .reset       (reset),
        .data_out    (data_out),
        .data_valide (data_valide),
        .keys_p1     (keys_p1),
        .keys_p2     (keys_p2)
    );

    sch_state_t state;
    logic       eof_q;
    logic [7:0] frame_cnt;
    logic [3:0] snap_p1;
    logic [3:0] snap_p2;
    logic       eof_rise;
    logic       tick;

    assign eof_rise = eof & ~eof_q;
    assign tick     = eof_rise && (frame_cnt == DIV_TOP);

    // Signed displacement along one axis; opposite keys cancel.
    function automatic logic signed [11:0] delta(input logic inc, input logic dec);
        if (inc == dec) return 12'sd0;
        return inc ? STEP_S : -STEP_S;
    endfunction

    function automatic coord_t clamp(input logic signed [11:0] v, input logic signed [11:0] hi);
        if (v < 12'sd0) return '0;
        if (v > hi)     return hi[10:0];
        return v[10:0];
    endfunction

    // Candidate for whichever player the scheduler is moving this cycle.
    // In MOVE_P2 the "other" position is p1's value committed one cycle ago.
    coord_t            cur_x, cur_y, oth_x, oth_y, cand_x, cand_y;
    logic [3:0]        mv_keys;
    logic signed [11:0] dx, dy;
    logic              blocked;

    // NOTE: every always_comb output is assigned on all paths (the if/else
    // covers both branches) so no latch is inferred.
    always_comb begin
        if (state == SCH_MOVE_P2) begin
            cur_x = p2_x;  cur_y = p2_y;  mv_keys = snap_p2;
            oth_x = p1_x;  oth_y = p1_y;
        end else begin
            cur_x = p1_x;  cur_y = p1_y;  mv_keys = snap_p1;
            oth_x = p2_x;  oth_y = p2_y;
        end
        dx = delta(mv_keys[0], mv_keys[1]);
`ifdef MOVE_DIAG_EN
        dy = delta(mv_keys[2], mv_keys[3]);
`else
        dy = (dx != 12'sd0) ? 12'sd0 : delta(mv_keys[2], mv_keys[3]);
`endif
        cand_x  = clamp($signed({cur_x[10], cur_x}) + dx, X_MAX);
        cand_y  = clamp($signed({cur_y[10], cur_y}) + dy, Y_MAX);
        blocked = (cand_x == oth_x) && (cand_y == oth_y);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SCH_IDLE;
            eof_q     <= 1'b0;
            frame_cnt <= 8'd0;
            snap_p1   <= 4'b0000;
            snap_p2   <= 4'b0000;
            p1_x      <= 11'(P1_X0);
            p1_y      <= 11'(P1_Y0);
            p2_x      <= 11'(P2_X0);
            p2_y      <= 11'(P2_Y0);
            upd_done  <= 1'b0;
        end else begin
            eof_q <= eof;
            // NOTE: default-low here makes upd_done a single-cycle pulse
            // without a separate clear state.
            upd_done <= 1'b0;
            if (eof_rise)
                frame_cnt <= (frame_cnt == DIV_TOP) ? 8'd0 : frame_cnt + 8'd1;

            case (state)
                SCH_IDLE:    if (tick) state <= SCH_SNAP;  // ticks while busy are dropped
                SCH_SNAP: begin
                    snap_p1 <= keys_p1;
                    snap_p2 <= keys_p2;
                    state   <= SCH_MOVE_P1;
                end
                SCH_MOVE_P1: begin
                    if (!blocked) begin
                        p1_x <= cand_x;
                        p1_y <= cand_y;
                    end
                    state <= SCH_MOVE_P2;
                end
                SCH_MOVE_P2: begin
                    if (!blocked) begin
                        p2_x <= cand_x;
                        p2_y <= cand_y;
                    end
                    state <= SCH_DONE;
                end
                SCH_DONE: begin
                    upd_done <= 1'b1;
                    state    <= SCH_IDLE;
                end
                default: state <= SCH_IDLE;
            endcase
        end
    end

endmodule
